// File: rtl/v_store_stream_ctrl.sv
// ---------------------------------------------------------------------------
// v_store_stream_ctrl
//
// Write-side feeder for the vector core's AXI master controller. Takes one
// store command (base address + word count), buffers the matching store
// data words in a first-word-fall-through FIFO, issues a one-cycle transfer
// request to the controller, streams the words out on wr_tvalid/wr_tready
// and, once the controller reports ctrl_wdone, pulses st_done back to the
// vector core.
//
// Ports
//   clk, rstn                 clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready       store command handshake
//   cmd_addr, cmd_len         byte base address (word aligned), word count
//   st_valid/st_ready/st_data store data stream from the vector core
//   ctrl_wstart               one-cycle transfer start pulse
//   ctrl_waddr_offset         transfer base address (held until IDLE)
//   ctrl_wxfer_size           transfer size in bytes (held until IDLE)
//   wr_tvalid/wr_tready/wr_tdata  write data stream to the controller
//   ctrl_wdone                controller write-complete pulse
//   st_done                   one-cycle completion pulse
//   busy                      high whenever a command is in progress
// ---------------------------------------------------------------------------
module v_store_stream_ctrl #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int LEN_WIDTH          = 16,
    parameter int FIFO_DEPTH         = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]          cmd_len,
    input  logic                          st_valid,
    output logic                          st_ready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] st_data,
    output logic                          ctrl_wstart,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_waddr_offset,
    output logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_wxfer_size,
    output logic                          wr_tvalid,
    input  logic                          wr_tready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] wr_tdata,
    input  logic                          ctrl_wdone,
    output logic                          st_done,
    output logic                          busy
);

    localparam int BYTES_PER_WORD = C_M_AXI_DATA_WIDTH / 8;
    localparam int PTR_W          = $clog2(FIFO_DEPTH);

    localparam logic [LEN_WIDTH:0] CNT_ONE       = (LEN_WIDTH+1)'(1);
    localparam logic [PTR_W-1:0]   PTR_ONE       = PTR_W'(1);
    localparam logic [PTR_W:0]     FIFO_CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]     FIFO_CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        STREAM,
        WAIT_DONE
    } state_t;

    state_t                        state_reg;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]          len_q;
    logic [C_XFER_SIZE_WIDTH-1:0]  xfer_size_reg;
    logic [LEN_WIDTH:0]            in_cnt_reg;
    logic [LEN_WIDTH:0]            out_cnt_reg;
    logic                          done_seen_reg;
    logic                          wstart_reg;
    logic                          st_done_reg;

    logic [C_M_AXI_DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]              wr_ptr_reg;
    logic [PTR_W-1:0]              rd_ptr_reg;
    logic [PTR_W:0]                fifo_cnt_reg;

    logic fifo_full;
    logic fifo_empty;
    logic cmd_fire;
    logic st_accept;
    logic wr_beat;
    logic last_beat;
    logic in_data_phase;

    assign fifo_full     = (fifo_cnt_reg == FIFO_CNT_FULL);
    assign fifo_empty    = (fifo_cnt_reg == '0);
    assign in_data_phase = (state_reg == START) || (state_reg == STREAM);

    // A command is refused during the st_done cycle so the next one lands
    // strictly after completion has been reported.
    assign cmd_ready = (state_reg == IDLE) && !st_done_reg;
    assign st_ready  = in_data_phase && !fifo_full && (in_cnt_reg < {1'b0, len_q});
    assign wr_tvalid = (state_reg == STREAM) && !fifo_empty;
    assign wr_tdata  = fifo_mem[rd_ptr_reg];

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign st_accept = st_valid && st_ready;
    assign wr_beat   = wr_tvalid && wr_tready;
    assign last_beat = wr_beat && ((out_cnt_reg + CNT_ONE) == {1'b0, len_q});

    assign ctrl_wstart       = wstart_reg;
    assign ctrl_waddr_offset = addr_q;
    assign ctrl_wxfer_size   = xfer_size_reg;
    assign st_done           = st_done_reg;
    assign busy              = (state_reg != IDLE);

    // FIFO storage: no reset so it maps onto distributed RAM. The head is
    // read combinationally, giving first-word-fall-through behaviour.
    always_ff @(posedge clk) begin
        if (st_accept) begin
            fifo_mem[wr_ptr_reg] <= st_data;
        end
    end

    // FIFO pointers and occupancy. A write cannot happen when full
    // (st_ready) and a read cannot happen when empty (wr_tvalid), so a
    // simultaneous write and read simply leaves the count unchanged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
        end else begin
            if (st_accept) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (wr_beat) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({st_accept, wr_beat})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + FIFO_CNT_ONE;
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - FIFO_CNT_ONE;
                default: fifo_cnt_reg <= fifo_cnt_reg;
            endcase
        end
    end

    // Control FSM with registered pulse outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            addr_q        <= '0;
            len_q         <= '0;
            xfer_size_reg <= '0;
            in_cnt_reg    <= '0;
            out_cnt_reg   <= '0;
            done_seen_reg <= 1'b0;
            wstart_reg    <= 1'b0;
            st_done_reg   <= 1'b0;
        end else begin
            wstart_reg  <= 1'b0;
            st_done_reg <= 1'b0;

            if (st_accept) begin
                in_cnt_reg <= in_cnt_reg + CNT_ONE;
            end
            if (wr_beat) begin
                out_cnt_reg <= out_cnt_reg + CNT_ONE;
            end

            case (state_reg)
                IDLE: begin
                    if (cmd_fire) begin
                        addr_q        <= cmd_addr;
                        len_q         <= cmd_len;
                        // Truncating the operands to the result width gives
                        // the product modulo 2^C_XFER_SIZE_WIDTH.
                        xfer_size_reg <= C_XFER_SIZE_WIDTH'(cmd_len) *
                                         C_XFER_SIZE_WIDTH'(BYTES_PER_WORD);
                        in_cnt_reg    <= '0;
                        out_cnt_reg   <= '0;
                        done_seen_reg <= 1'b0;
                        if (cmd_len == '0) begin
                            // Nothing to move: report completion directly.
                            st_done_reg <= 1'b1;
                        end else begin
                            state_reg  <= START;
                            wstart_reg <= 1'b1;
                        end
                    end
                end

                START: begin
                    state_reg <= STREAM;
                end

                STREAM: begin
                    if (last_beat) begin
                        // The controller may already have reported done
                        // (now or earlier); finish without visiting WAIT_DONE.
                        if (ctrl_wdone || done_seen_reg) begin
                            state_reg     <= IDLE;
                            st_done_reg   <= 1'b1;
                            done_seen_reg <= 1'b0;
                        end else begin
                            state_reg <= WAIT_DONE;
                        end
                    end else if (ctrl_wdone) begin
                        done_seen_reg <= 1'b1;
                    end
                end

                WAIT_DONE: begin
                    if (done_seen_reg || ctrl_wdone) begin
                        state_reg     <= IDLE;
                        st_done_reg   <= 1'b1;
                        done_seen_reg <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_v_store_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_v_store_stream_ctrl
//
// Directed + randomized bench for v_store_stream_ctrl. Each transaction is
// checked cycle by cycle against a reference built from the protocol rules:
// a queue holds the words that should be buffered, and completion is
// expected one cycle after the later of the last write beat and the first
// ctrl_wdone seen once streaming has begun.
// ---------------------------------------------------------------------------
module tb_v_store_stream_ctrl;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int XW    = 32;
    localparam int LW    = 16;
    localparam int DEPTH = 16;
    localparam int BPW   = DW / 8;
    localparam int BUDGET = 2000;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          st_valid;
    logic          st_ready;
    logic [DW-1:0] st_data;
    logic          ctrl_wstart;
    logic [AW-1:0] ctrl_waddr_offset;
    logic [XW-1:0] ctrl_wxfer_size;
    logic          wr_tvalid;
    logic          wr_tready;
    logic [DW-1:0] wr_tdata;
    logic          ctrl_wdone;
    logic          st_done;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    v_store_stream_ctrl #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW),
        .C_XFER_SIZE_WIDTH (XW),
        .LEN_WIDTH         (LW),
        .FIFO_DEPTH        (DEPTH)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_addr         (cmd_addr),
        .cmd_len          (cmd_len),
        .st_valid         (st_valid),
        .st_ready         (st_ready),
        .st_data          (st_data),
        .ctrl_wstart      (ctrl_wstart),
        .ctrl_waddr_offset(ctrl_waddr_offset),
        .ctrl_wxfer_size  (ctrl_wxfer_size),
        .wr_tvalid        (wr_tvalid),
        .wr_tready        (wr_tready),
        .wr_tdata         (wr_tdata),
        .ctrl_wdone       (ctrl_wdone),
        .st_done          (st_done),
        .busy             (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".cmd_ready"},   64'(cmd_ready),         64'd1);
        chk({tag, ".busy"},        64'(busy),              64'd0);
        chk({tag, ".ctrl_wstart"}, 64'(ctrl_wstart),       64'd0);
        chk({tag, ".st_ready"},    64'(st_ready),          64'd0);
        chk({tag, ".wr_tvalid"},   64'(wr_tvalid),         64'd0);
        chk({tag, ".st_done"},     64'(st_done),           64'd0);
        chk({tag, ".offset"},      64'(ctrl_waddr_offset), 64'd0);
        chk({tag, ".size"},        64'(ctrl_wxfer_size),   64'd0);
    endtask

    task automatic idle_inputs();
        cmd_valid  = 1'b0;
        cmd_addr   = '0;
        cmd_len    = '0;
        st_valid   = 1'b0;
        st_data    = '0;
        wr_tready  = 1'b0;
        ctrl_wdone = 1'b0;
    endtask

    // done_mode 0: pulse ctrl_wdone done_delay cycles after the last beat.
    // done_mode 1: pulse ctrl_wdone together with the last beat.
    // early_done:  also pulse ctrl_wdone in the command cycle and in START.
    // abort_beats: if >0, pull rstn low once that many beats have completed.
    task automatic run_xfer(input string name, input logic [31:0] addr, input int len,
                            input int n_supply, input logic [31:0] data_base,
                            input bit rnd_data, input int valid_pct, input int ready_pct,
                            input int stall, input int done_mode, input int done_delay,
                            input bit early_done, input int abort_beats);
        logic [31:0] src[$];
        logic [31:0] q[$];
        logic [31:0] exp_size;
        int  k = -1;
        int  accepted = 0;
        int  beats = 0;
        int  last_edge = -1;
        int  done_edge = -1;
        int  done_cyc = -1;
        bit  finished = 1'b0;
        bit  in_xfer, e_cmd_ready, e_busy, e_wstart, e_st_ready, e_wr_tvalid, e_st_done;

        exp_size = 32'(len * BPW);
        for (int i = 0; i < n_supply; i++) begin
            src.push_back(rnd_data ? $urandom : data_base + 32'(i));
        end

        for (int n = 0; n < BUDGET; n++) begin
            @(negedge clk);
            in_xfer     = (k >= 0) && (done_cyc < 0 || n < done_cyc);
            e_cmd_ready = (k < 0) || (done_cyc >= 0 && n > done_cyc);
            e_busy      = in_xfer && (len > 0);
            e_wstart    = (len > 0) && (n == k);
            e_st_ready  = e_busy && (q.size() < DEPTH) && (accepted < len);
            e_wr_tvalid = in_xfer && (n > k) && (q.size() > 0);
            e_st_done   = (n == done_cyc);

            chk({name, ".cmd_ready"},   64'(cmd_ready),   64'(e_cmd_ready));
            chk({name, ".busy"},        64'(busy),        64'(e_busy));
            chk({name, ".ctrl_wstart"}, 64'(ctrl_wstart), 64'(e_wstart));
            chk({name, ".st_ready"},    64'(st_ready),    64'(e_st_ready));
            chk({name, ".wr_tvalid"},   64'(wr_tvalid),   64'(e_wr_tvalid));
            chk({name, ".st_done"},     64'(st_done),     64'(e_st_done));
            if (e_busy) begin
                chk({name, ".offset"}, 64'(ctrl_waddr_offset), 64'(addr));
                chk({name, ".size"},   64'(ctrl_wxfer_size),   64'(exp_size));
            end
            if (e_wr_tvalid) begin
                chk({name, ".wr_tdata"}, 64'(wr_tdata), 64'(q[0]));
            end

            if (done_cyc >= 0 && n > done_cyc) begin
                finished = 1'b1;
                break;
            end

            if (abort_beats > 0 && beats == abort_beats) begin
                idle_inputs();
                rstn = 1'b0;
                #1;
                chk_reset_values({name, ".async_rst"});
                repeat (3) begin
                    @(negedge clk);
                    chk_reset_values({name, ".held_rst"});
                end
                rstn = 1'b1;
                $display("xfer %s addr=%h len=%0d aborted by reset after %0d beats",
                         name, addr, len, beats);
                return;
            end

            // Inputs for cycle n (sampled at the next rising edge).
            cmd_valid  = (k < 0);
            cmd_addr   = addr;
            cmd_len    = LW'(len);
            st_valid   = (accepted < n_supply) && (int'($urandom_range(99)) < valid_pct);
            st_data    = (accepted < n_supply) ? src[accepted] : '0;
            wr_tready  = (n >= stall) && (int'($urandom_range(99)) < ready_pct);
            ctrl_wdone = 1'b0;
            if (early_done && (k < 0 || n == k)) ctrl_wdone = 1'b1;
            if (done_mode == 0 && last_edge >= 0 && n == last_edge + done_delay - 1) ctrl_wdone = 1'b1;
            if (done_mode == 1 && e_wr_tvalid && wr_tready && beats == len - 1) ctrl_wdone = 1'b1;

            // Reference update for the coming edge.
            if (k < 0 && e_cmd_ready) begin
                k = n + 1;
                if (len == 0) done_cyc = k;
            end
            if (st_valid && e_st_ready) begin
                q.push_back(src[accepted]);
                accepted++;
            end
            if (wr_tready && e_wr_tvalid) begin
                void'(q.pop_front());
                beats++;
                if (beats == len) last_edge = n + 1;
            end
            if (ctrl_wdone && in_xfer && n > k && done_edge < 0) done_edge = n + 1;
            if (len > 0 && done_cyc < 0 && last_edge >= 0 && done_edge >= 0) begin
                done_cyc = (last_edge > done_edge) ? last_edge : done_edge;
            end
        end

        if (!finished) chk({name, ".timeout"}, 64'd0, 64'd1);
        idle_inputs();
        $display("xfer %s addr=%h len=%0d accepted=%0d beats=%0d st_done_cycle=%0d",
                 name, addr, len, accepted, beats, done_cyc);
    endtask

    initial begin
        idle_inputs();

        // Reset and check the reset state.
        #3 rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_values("reset");
        rstn = 1'b1;

        // Basic transfer: A0..A3 back-to-back, done 3 cycles after last beat.
        run_xfer("basic", 32'h0000_1000, 4, 4, 32'hA0, 1'b0, 100, 100, 0, 0, 3, 1'b0, 0);

        // Backpressure: more words than the FIFO holds, sink stalled 30 cycles.
        run_xfer("backpressure", 32'h0000_2000, 20, 20, 32'h0, 1'b0, 100, 100, 30, 0, 2, 1'b0, 0);

        // Zero length: immediate completion, no start, no stream.
        run_xfer("zero_len", 32'h0000_3000, 0, 0, 32'h0, 1'b0, 100, 100, 0, 0, 1, 1'b0, 0);

        // Done coincident with the last beat.
        run_xfer("coincident", 32'h0000_4000, 6, 6, 32'h0, 1'b1, 100, 100, 0, 1, 1, 1'b0, 0);

        // Over-supply: five words offered for a two-word command.
        run_xfer("oversupply", 32'h0000_5000, 2, 5, 32'hB0, 1'b0, 100, 100, 0, 0, 2, 1'b0, 0);

        // ctrl_wdone pulses in IDLE and START must be ignored.
        run_xfer("early_done", 32'h0000_6000, 3, 3, 32'hC0, 1'b0, 100, 100, 0, 0, 2, 1'b1, 0);

        // Reset mid-stream after 3 of 8 beats, then a normal single word.
        run_xfer("rst_mid", 32'h0000_7000, 8, 8, 32'hD0, 1'b0, 100, 100, 0, 0, 2, 1'b0, 3);
        run_xfer("after_rst", 32'h0000_8000, 1, 1, 32'hE0, 1'b0, 100, 100, 0, 0, 1, 1'b0, 0);

        // Randomized transactions.
        for (int t = 0; t < 20; t++) begin
            int len_r;
            len_r = int'($urandom_range(40));
            run_xfer("random", $urandom & 32'hFFFF_FFFC, len_r,
                     len_r + int'($urandom_range(3)), 32'h0, 1'b1,
                     int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                     int'($urandom_range(5)), int'($urandom_range(1)),
                     int'($urandom_range(1, 5)), 1'($urandom_range(1)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
